// File: rtl/mux_sel_ctrl.sv
// Select-line controller for the lab 2-to-1 mux: synchronised, debounced
// pushbutton toggles sel; optional auto mode toggles sel every AUTO_PERIOD cycles.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | button went high, waiting for it to stay high
// PRESSED      | press accepted, button held
// RELEASE_WAIT | button went low, waiting for it to stay low
module mux_sel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned AUTO_PERIOD     = 50000000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             auto_en,
    output logic             sel,
    output logic             press_pulse,
    output logic             btn_state,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned AW = $clog2(AUTO_PERIOD);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       btn_sync_q, btn_sync_d;
    logic [1:0]       auto_sync_q, auto_sync_d;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [AW-1:0]    auto_cnt_q, auto_cnt_d;
    logic             sel_q, sel_d;
    logic             press_pulse_q, press_pulse_d;
    logic             btn_state_q, btn_state_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;

    logic btn_s;
    logic auto_s;
    logic accept;
    logic auto_wrap;

    assign btn_s  = btn_sync_q[1];
    assign auto_s = auto_sync_q[1];

    always_comb begin
        btn_sync_d  = {btn_sync_q[0], btn_raw};
        auto_sync_d = {auto_sync_q[0], auto_en};
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    accept  = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                // a bounce back high resumes the held press without counting it again
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        auto_wrap = auto_s && (auto_cnt_q == AUTO_LAST);
        if (!auto_s || accept || auto_wrap) begin
            auto_cnt_d = '0;
        end else begin
            auto_cnt_d = auto_cnt_q + 1'b1;
        end
        // a press landing on an auto wrap must toggle sel only once
        sel_d         = sel_q ^ (accept | auto_wrap);
        press_pulse_d = accept;
        press_count_d = press_count_q + CNT_W'(accept);
        btn_state_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            btn_sync_q    <= '0;
            auto_sync_q   <= '0;
            deb_cnt_q     <= '0;
            auto_cnt_q    <= '0;
            sel_q         <= 1'b0;
            press_pulse_q <= 1'b0;
            btn_state_q   <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            btn_sync_q    <= btn_sync_d;
            auto_sync_q   <= auto_sync_d;
            deb_cnt_q     <= deb_cnt_d;
            auto_cnt_q    <= auto_cnt_d;
            sel_q         <= sel_d;
            press_pulse_q <= press_pulse_d;
            btn_state_q   <= btn_state_d;
            press_count_q <= press_count_d;
        end
    end

    assign sel         = sel_q;
    assign press_pulse = press_pulse_q;
    assign btn_state   = btn_state_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl with short debounce and auto periods.
module tb_mux_sel_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned AUTO  = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             btn_raw;
    logic             auto_en;
    logic             sel;
    logic             press_pulse;
    logic             btn_state;
    logic [CNT_W-1:0] press_count;

    int n_checks;
    int n_errors;

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_PERIOD    (AUTO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .auto_en    (auto_en),
        .sel        (sel),
        .press_pulse(press_pulse),
        .btn_state  (btn_state),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 1'b0;
        auto_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // 1: reset with inputs active, then full latency after release
        rst     = 1'b1;
        btn_raw = 1'b1;
        auto_en = 1'b1;
        repeat (3) tick();
        chk("rst_sel", sel, 0);
        chk("rst_pulse", press_pulse, 0);
        chk("rst_btn_state", btn_state, 0);
        chk("rst_count", press_count, 0);
        rst     = 1'b0;
        auto_en = 1'b0;
        repeat (6) tick();
        chk("rst_lat_sel_early", sel, 0);
        tick();
        chk("rst_lat_sel", sel, 1);
        chk("rst_lat_count", press_count, 1);

        // 2: clean press / release / press
        do_reset();
        btn_raw = 1'b1;
        repeat (6) tick();
        chk("p1_sel_before", sel, 0);
        chk("p1_pulse_before", press_pulse, 0);
        tick();
        chk("p1_sel", sel, 1);
        chk("p1_pulse", press_pulse, 1);
        chk("p1_count", press_count, 1);
        chk("p1_btn_state", btn_state, 1);
        tick();
        chk("p1_pulse_drop", press_pulse, 0);
        chk("p1_sel_hold", sel, 1);
        repeat (12) tick();
        btn_raw = 1'b0;
        repeat (20) tick();
        chk("rel_btn_state", btn_state, 0);
        chk("rel_sel", sel, 1);
        chk("rel_count", press_count, 1);
        btn_raw = 1'b1;
        repeat (7) tick();
        chk("p2_sel", sel, 0);
        chk("p2_pulse", press_pulse, 1);
        chk("p2_count", press_count, 2);
        repeat (13) tick();
        btn_raw = 1'b0;
        repeat (10) tick();

        // 3: bounce rejection, then a short low glitch while held
        do_reset();
        for (int b = 0; b < 5; b++) begin
            btn_raw = 1'b1;
            repeat (3) tick();
            btn_raw = 1'b0;
            repeat (3) tick();
            chk("bounce_sel", sel, 0);
            chk("bounce_btn_state", btn_state, 0);
        end
        repeat (6) tick();
        chk("bounce_count", press_count, 0);
        btn_raw = 1'b1;
        repeat (7) tick();
        chk("glitch_pre_state", btn_state, 1);
        chk("glitch_pre_count", press_count, 1);
        btn_raw = 1'b0;
        tick();
        btn_raw = 1'b1;
        for (int g = 0; g < 8; g++) begin
            tick();
            chk("glitch_btn_state", btn_state, 1);
            chk("glitch_pulse", press_pulse, 0);
        end
        chk("glitch_count", press_count, 1);
        chk("glitch_sel", sel, 1);
        btn_raw = 1'b0;
        repeat (10) tick();

        // 4: auto toggling every 8 cycles, then hold
        do_reset();
        auto_en = 1'b1;
        for (int n = 1; n <= 42; n++) begin
            tick();
            chk($sformatf("auto_sel_t%0d", n), sel, (n >= 10) ? (((n - 10) / 8 + 1) % 2) : 0);
        end
        auto_en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("auto_off_hold", sel, 1);
        end

        // 5: press accepted on the same edge as an auto wrap
        do_reset();
        auto_en = 1'b1;
        repeat (11) tick();
        btn_raw = 1'b1;
        repeat (6) tick();
        chk("coll_sel_before", sel, 1);
        chk("coll_pulse_before", press_pulse, 0);
        tick();
        chk("coll_sel", sel, 0);
        chk("coll_pulse", press_pulse, 1);
        chk("coll_count", press_count, 1);
        repeat (7) tick();
        chk("coll_next_early", sel, 0);
        tick();
        chk("coll_next", sel, 1);
        auto_en = 1'b0;
        btn_raw = 1'b0;
        repeat (10) tick();

        // 6: press counter wrap
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            btn_raw = 1'b1;
            repeat (8) tick();
            btn_raw = 1'b0;
            repeat (8) tick();
            chk($sformatf("wrap_count_p%0d", p), press_count, p % 16);
            chk($sformatf("wrap_sel_p%0d", p), sel, p % 2);
        end
        chk("wrap_final_count", press_count, 0);
        chk("wrap_final_sel", sel, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
